count_display_mux: RTL
======================

# count_display_mux

Downstream consumer of the 8-bit ripple counter. It samples the counter's asynchronous, non-atomically settling outputs into the system clock domain and accepts a value only when it is stable. It then drives the accepted value as two hex digits on a time-multiplexed, active-low seven-segment display. It is the last stage between the counter and the board pins.

## Interface
- REFRESH_CYCLES, default 50000: clock cycles each digit is enabled; legal range ≥ 2.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset.
- count_in  input  8  raw ripple-counter outputs; asynchronous to clk; may glitch through intermediate codes.
- hold  input  1  synchronous to clk; 1 freezes the accepted value.
- value  output  8  last accepted stable count.
- upd  output  1  one-cycle pulse in the cycle `value` changes.
- seg  output  7  active-low segments, {g,f,e,d,c,b,a}.
- an  output  2  active-low digit enables; an[0] = low nibble, an[1] = high nibble.

## Operation
- Sampler:
  - Three-register chain each cycle: s1 ← count_in, s2 ← s1, s3 ← s2.
  - Stable: s2 == s3.
  - Accept when stable, s2 ≠ value, and hold == 0: value ← s2 and upd ← 1 on the same edge.
  - Otherwise upd ← 0.
- A code present in only one sample (a ripple transient) is never accepted.
- Hold:
  - Sampling continues while hold is 1; only acceptance is blocked.
  - On release, the first stable differing sample is accepted normally.
  - No pulse is emitted if the count is unchanged.
- Refresh:
  - Counter rc runs 0..REFRESH_CYCLES-1 and wraps.
  - digit toggles 0↔1 on the wrap edge.
  - Width of rc is $clog2(REFRESH_CYCLES).
- Ghost guard: in the cycle where rc == 0, an ← 2'b11 and seg ← 7'h7F (all off).
- Drive, for all other rc values:
  - digit 0: an ← 2'b10, seg ← hex(value[3:0]).
  - digit 1: an ← 2'b01, seg ← hex(value[7:4]).
- Hex decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset (reset == 0 at an edge):
  - s1, s2, s3, value, rc, digit ← 0; upd ← 0; an ← 2'b11; seg ← 7'h7F.
  - Reset wins over every other event and applies mid-operation.
  - After release, the first display slot begins at rc == 0 (guard cycle) with digit 0.

## Timing
- Acceptance latency: count_in stable before edge E1 → s1 at E1, s2 at E2, s3 at E3 → value and upd updated at E4. Minimum is 4 edges.
- count_in changing every cycle is never accepted.
- seg and an are registered: a new value appears on seg one edge after the value update, provided the matching digit is active and not in guard.
- A digit slot is REFRESH_CYCLES cycles long: 1 guard cycle plus REFRESH_CYCLES-1 driven cycles. Full frame = 2·REFRESH_CYCLES.
- Simultaneous acceptance and digit toggle: both take effect on the same edge. seg uses the pre-edge value; no special case.
- upd never stays high for two consecutive cycles unless value changes on consecutive edges. Sustaining that requires two distinct stable codes, so it cannot occur: two stable codes are at least two cycles apart.

## Structure
- Package `count_display_pkg`:
  - SEG_BLANK = 7'h7F.
  - AN_OFF = 2'b11.
  - 16-entry hex segment table as a function hex_to_seg(logic [3:0]) → logic [6:0].
- Sub-module `seg7_hex_decoder`: purely combinational wrapper of hex_to_seg. It is instantiated once, muxed by digit.
- Top module contains the sampler, refresh counter, and output registers.

## Test plan
- Reset: hold reset = 0 for 3 cycles with count_in = 8'hFF → value = 0, upd = 0, an = 2'b11, seg = 7'h7F. After release, the guard cycle is followed by an = 2'b10, seg = 1000000.
- Stable capture: count_in = 8'h3A held → upd pulses exactly once at edge 4. value = 8'h3A. With REFRESH_CYCLES = 4: digit 0 shows seg = 0001000 (A), digit 1 shows seg = 0110000 (3), with an alternating 10/01 separated by 11 guard cycles.
- Glitch rejection: count_in = 8'h07 stable, then one cycle of 8'h00, then 8'h08 stable → value goes 8'h07 → 8'h08. 8'h00 is never accepted; upd pulses twice in total.
- Hold: value = 8'h10, hold = 1, count_in = 8'h11 stable for 10 cycles → value stays 8'h10, no upd. Release hold → value = 8'h11 on the next edge with one upd pulse.
- Mid-operation reset: assert reset for 1 cycle during digit 1 with value = 8'hC5 → next cycle value = 0, digit = 0, an = 2'b11, rc = 0.
- Wrap: with REFRESH_CYCLES = 3, check that an follows the period-6 pattern 11,10,10,11,01,01.

Source files
------------

// File: rtl/count_display_pkg.sv
`default_nettype none
// ============================================================================
// Module      : count_display_pkg
// Description : Shared constants and the active-low hex-to-seven-segment
//               table for the ripple-counter display path.
//               Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
// Revision    : 1.0 - initial release
// ============================================================================
package count_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (nib)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage : count_display_pkg
`default_nettype wire

// File: rtl/seg7_hex_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seg7_hex_decoder
// Description : Combinational hex nibble to active-low seven-segment decode.
// Ports       : i_hex  [3:0]  nibble to display
//               o_seg  [6:0]  active-low segments {g,f,e,d,c,b,a}
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decoder
    import count_display_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg(i_hex);

endmodule : seg7_hex_decoder
`default_nettype wire

// File: rtl/count_display_mux.sv
`default_nettype none
// ============================================================================
// Module      : count_display_mux
// Description : Samples asynchronous ripple-counter outputs, accepts a value
//               only after two consecutive identical samples, and shows the
//               accepted byte as two hex digits on a multiplexed active-low
//               seven-segment display with a blanking guard cycle per slot.
// Ports       : clk            system clock
//               reset          synchronous active-low reset
//               count_in [7:0] raw ripple-counter outputs (asynchronous)
//               hold           1 freezes the accepted value
//               value    [7:0] last accepted stable count
//               upd            one-cycle pulse when value changes
//               seg      [6:0] active-low segments {g,f,e,d,c,b,a}
//               an       [1:0] active-low digit enables (an[0] = low nibble)
// Revision    : 1.0 - initial release
// ============================================================================
module count_display_mux
    import count_display_pkg::*;
#(
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] count_in,
    input  logic       hold,
    output logic [7:0] value,
    output logic       upd,
    output logic [6:0] seg,
    output logic [1:0] an
);

    localparam int             RC_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [RC_W-1:0] c_rc_last = RC_W'(REFRESH_CYCLES - 1);
    localparam logic [RC_W-1:0] c_rc_one  = RC_W'(1);

    // s1 is the metastability-catching stage; s2/s3 compare two settled
    // samples so a code seen in only one sample is never taken.
    logic [7:0]      r_s1;
    logic [7:0]      r_s2;
    logic [7:0]      r_s3;
    logic [7:0]      r_value;
    logic            r_upd;
    logic [RC_W-1:0] r_rc;
    logic            r_digit;
    logic [6:0]      r_seg;
    logic [1:0]      r_an;

    logic [3:0]      w_nibble;
    logic [6:0]      w_seg;
    logic            w_accept;

    assign w_nibble = r_digit ? r_value[7:4] : r_value[3:0];
    assign w_accept = (r_s2 == r_s3) && (r_s2 != r_value) && !hold;

    seg7_hex_decoder u_dec (
        .i_hex (w_nibble),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_value <= '0;
            r_upd   <= 1'b0;
            r_rc    <= '0;
            r_digit <= 1'b0;
            r_an    <= AN_OFF;
            r_seg   <= SEG_BLANK;
        end else begin
            r_s1 <= count_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (w_accept) begin
                r_value <= r_s2;
                r_upd   <= 1'b1;
            end else begin
                r_upd   <= 1'b0;
            end

            if (r_rc == c_rc_last) begin
                r_rc    <= '0;
                r_digit <= ~r_digit;
            end else begin
                r_rc    <= r_rc + c_rc_one;
            end

            // First cycle of each slot is blanked so the previous digit's
            // segments never ghost onto the newly enabled anode.
            if (r_rc == '0) begin
                r_an  <= AN_OFF;
                r_seg <= SEG_BLANK;
            end else begin
                r_an  <= r_digit ? 2'b01 : 2'b10;
                r_seg <= w_seg;
            end
        end
    end

    assign value = r_value;
    assign upd   = r_upd;
    assign seg   = r_seg;
    assign an    = r_an;

endmodule : count_display_mux
`default_nettype wire
